// File: rtl/addac_pkg.sv
// Shared types for the addac_n accumulator: operation codes, FSM states and
// a helper that sizes the beat counter.
package addac_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_HOLD = 2'b11
  } addac_op_t;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } addac_state_t;

  // Counter must represent 0..max_beats inclusive.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/addac_alu.sv
// Combinational accumulate step: computes the next accumulator value and the
// carry/borrow for one operand beat, optionally saturating.
module addac_alu
  import addac_pkg::*;
#(
  parameter int W   = 8,
  parameter int SAT = 0
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  addac_op_t    op,
  output logic [W-1:0] next_acc,
  output logic         carry
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_diff;
  logic         w_borrow;

  assign w_sum    = {1'b0, acc} + {1'b0, a};
  assign w_diff   = acc - a;
  assign w_borrow = (acc < a);

  always_comb begin
    next_acc = acc;
    carry    = 1'b0;
    unique case (op)
      OP_LOAD: next_acc = a;
      OP_ADD: begin
        carry    = w_sum[W];
        next_acc = ((SAT != 0) && w_sum[W]) ? {W{1'b1}} : w_sum[W-1:0];
      end
      OP_SUB: begin
        carry    = w_borrow;
        next_acc = ((SAT != 0) && w_borrow) ? '0 : w_diff;
      end
      default: next_acc = acc;
    endcase
  end

endmodule

// File: rtl/addac_n.sv
// Framed W-bit accumulator: accepts operand beats on a valid/ready stream,
// closes a frame on in_last or MAX_BEATS beats and holds the result until taken.
module addac_n
  import addac_pkg::*;
#(
  parameter int  W           = 8,
  parameter int  MAX_BEATS   = 16,
  parameter int  SAT         = 0,
  parameter int  CLR_ON_DONE = 1,
  localparam int CW          = cnt_width(MAX_BEATS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  a,
  input  logic [1:0]    sel,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [W-1:0]  s,
  output logic          cout,
  output logic          ovf,
  output logic [CW-1:0] beat_cnt,
  output logic          out_valid,
  input  logic          out_ready
);

  addac_state_t  r_state, w_state_nxt;
  logic [W-1:0]  r_s;
  logic          r_cout;
  logic          r_ovf;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_alu_s;
  logic          w_alu_c;
  logic          w_accept;
  logic          w_out_hs;
  logic [CW-1:0] w_cnt_inc;
  logic          w_close;

  addac_alu #(.W(W), .SAT(SAT)) u_alu (
    .acc      (r_s),
    .a        (a),
    .op       (addac_op_t'(sel)),
    .next_acc (w_alu_s),
    .carry    (w_alu_c)
  );

  assign w_accept  = in_valid && (r_state == ST_ACC);
  assign w_out_hs  = out_ready && (r_state == ST_DONE);
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_close   = in_last || (w_cnt_inc == CW'(MAX_BEATS));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_ACC:  if (w_accept && w_close) w_state_nxt = ST_DONE;
      ST_DONE: if (w_out_hs) w_state_nxt = ST_ACC;
      default: w_state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ACC;
    else     r_state <= w_state_nxt;
  end

  // Datapath only moves on an accepted beat or the output handshake; the
  // operand inputs are never looked at otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_s    <= w_alu_s;
      r_cout <= w_alu_c;
      r_ovf  <= r_ovf | w_alu_c;
      r_cnt  <= w_cnt_inc;
    end else if (w_out_hs) begin
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_cnt  <= '0;
      if (CLR_ON_DONE != 0) r_s <= '0;
    end
  end

  assign in_ready  = (r_state == ST_ACC);
  assign out_valid = (r_state == ST_DONE);
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_addac_n.sv
// Bench for addac_n: three instances (wrap/clear, saturate/clear, wrap/retain)
// share one stimulus stream; frame results are checked through a scoreboard.
module tb_addac_n;
  import addac_pkg::*;

  localparam int W  = 8;
  localparam int MB = 4;
  localparam int CW = 3;
  localparam int ND = 3;

  typedef struct packed {
    logic [W-1:0]  s;
    logic          c;
    logic          o;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  a;
  logic [1:0]    sel;
  logic          in_valid, in_last, out_ready;

  logic          ir_o  [ND];
  logic [W-1:0]  s_o   [ND];
  logic          c_o   [ND];
  logic          ovf_o [ND];
  logic [CW-1:0] cnt_o [ND];
  logic          ov_o  [ND];

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q0[$], q1[$], q2[$];

  logic [W-1:0]  m_s [ND];
  logic          m_c [ND];
  logic          m_o [ND];
  logic [CW-1:0] m_cnt;
  bit            m_done;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    addac_n #(
      .W(W), .MAX_BEATS(MB), .SAT((g == 1) ? 1 : 0), .CLR_ON_DONE((g == 2) ? 0 : 1)
    ) dut (
      .clk(clk), .rst(rst), .a(a), .sel(sel), .in_valid(in_valid), .in_last(in_last),
      .in_ready(ir_o[g]), .s(s_o[g]), .cout(c_o[g]), .ovf(ovf_o[g]), .beat_cnt(cnt_o[g]),
      .out_valid(ov_o[g]), .out_ready(out_ready)
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference step returning {carry, next acc}, written with integer arithmetic.
  function automatic logic [W:0] ref_step(input logic [W-1:0] acc, input logic [W-1:0] op_a,
                                          input logic [1:0] op, input bit sat);
    int t;
    logic [W-1:0] r;
    case (op)
      2'b00: return {1'b0, op_a};
      2'b01: begin
        t = int'(acc) + int'(op_a);
        r = t[W-1:0];
        if (t > 255) return sat ? {1'b1, 8'hFF} : {1'b1, r};
        return {1'b0, r};
      end
      2'b10: begin
        t = int'(acc) - int'(op_a);
        r = t[W-1:0];
        if (t < 0) return sat ? {1'b1, 8'h00} : {1'b1, r};
        return {1'b0, r};
      end
      default: return {1'b0, acc};
    endcase
  endfunction

  task automatic push_exp(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int k, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '0;
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic model_reset();
    for (int k = 0; k < ND; k++) begin
      m_s[k] = '0; m_c[k] = 1'b0; m_o[k] = 1'b0;
    end
    m_cnt  = '0;
    m_done = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                       input logic last, input logic ordy);
    in_valid = v; sel = op; a = d; in_last = last; out_ready = ordy;
  endtask

  // Advances the model with the currently driven inputs, then one clock.
  task automatic tick();
    logic [W:0] r;
    exp_t e;
    if (in_valid && !m_done) begin
      for (int k = 0; k < ND; k++) begin
        r = ref_step(m_s[k], a, sel, k == 1);
        m_s[k] = r[W-1:0];
        m_c[k] = r[W];
        m_o[k] = m_o[k] | r[W];
      end
      m_cnt = m_cnt + 3'd1;
      if (in_last || m_cnt == 3'(MB)) begin
        m_done = 1'b1;
        for (int k = 0; k < ND; k++) begin
          e = '{s: m_s[k], c: m_c[k], o: m_o[k], cnt: m_cnt};
          push_exp(k, e);
        end
      end
    end else if (m_done && out_ready) begin
      m_done = 1'b0;
      m_cnt  = '0;
      for (int k = 0; k < ND; k++) begin
        m_c[k] = 1'b0; m_o[k] = 1'b0;
        if (k != 2) m_s[k] = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    bit   seen [ND];
    bit   ok;
    exp_t e;
    for (int k = 0; k < ND; k++) seen[k] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < ND; k++) begin
        if (rst) seen[k] = 1'b0;
        else if (ov_o[k] && !seen[k]) begin
          seen[k] = 1'b1;
          pop_exp(k, ok, e);
          chk($sformatf("sb_present_d%0d", k), 32'(ok), 32'd1);
          if (ok) begin
            chk($sformatf("sb_s_d%0d", k), 32'(s_o[k]), 32'(e.s));
            chk($sformatf("sb_cout_d%0d", k), 32'(c_o[k]), 32'(e.c));
            chk($sformatf("sb_ovf_d%0d", k), 32'(ovf_o[k]), 32'(e.o));
            chk($sformatf("sb_cnt_d%0d", k), 32'(cnt_o[k]), 32'(e.cnt));
          end
        end else if (!ov_o[k]) seen[k] = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    model_reset();
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_s", 32'(s_o[0]), 32'h0);
    chk("rst_ov", 32'(ov_o[0]), 32'h0);
    chk("rst_ir", 32'(ir_o[0]), 32'h1);

    // 1: async reset mid-frame
    drive(1'b1, 2'b00, 8'h37, 1'b0, 1'b0); tick();
    chk("t1_s_loaded", 32'(s_o[0]), 32'h37);
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_s", 32'(s_o[0]), 32'h0);
    chk("t1_async_cnt", 32'(cnt_o[0]), 32'h0);
    chk("t1_async_cout_ovf", {30'd0, c_o[0], ovf_o[0]}, 32'h0);
    chk("t1_async_ov", 32'(ov_o[0]), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("t1_ir_after", 32'(ir_o[0]), 32'h1);

    // 2: wrap with carry, DONE ignores beats, handshake clears
    drive(1'b1, 2'b00, 8'hF0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b01, 8'h20, 1'b1, 1'b0); tick();
    chk("t2_s", 32'(s_o[0]), 32'h10);
    chk("t2_cout", 32'(c_o[0]), 32'h1);
    chk("t2_ovf", 32'(ovf_o[0]), 32'h1);
    chk("t2_ov", 32'(ov_o[0]), 32'h1);
    chk("t2_ir", 32'(ir_o[0]), 32'h0);
    chk("t3_sat_s", 32'(s_o[1]), 32'hFF);
    chk("t3_sat_cout", 32'(c_o[1]), 32'h1);
    drive(1'b1, 2'b01, 8'h55, 1'b0, 1'b0); tick();
    chk("t2_done_frozen_s", 32'(s_o[0]), 32'h10);
    chk("t2_done_frozen_cnt", 32'(cnt_o[0]), 32'h2);
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1); tick();
    chk("t2_hs_s", 32'(s_o[0]), 32'h0);
    chk("t2_hs_ovf", 32'(ovf_o[0]), 32'h0);
    chk("t2_hs_cnt", 32'(cnt_o[0]), 32'h0);
    chk("t2_hs_ir", 32'(ir_o[0]), 32'h1);
    chk("t2_keep_s", 32'(s_o[2]), 32'h10);

    // 3: subtract with borrow, saturating vs wrapping
    drive(1'b1, 2'b00, 8'h05, 1'b0, 1'b0); tick();
    drive(1'b1, 2'b10, 8'h09, 1'b1, 1'b0); tick();
    chk("t3_sat_sub_s", 32'(s_o[1]), 32'h00);
    chk("t3_sat_sub_cout", 32'(c_o[1]), 32'h1);
    chk("t3_wrap_sub_s", 32'(s_o[0]), 32'hFC);
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1); tick();

    // 4: MAX_BEATS closes the frame, with and without in_last on the last beat
    for (int rep = 0; rep < 2; rep++) begin
      drive(1'b1, 2'b00, 8'h01, 1'b0, 1'b0); tick();
      drive(1'b1, 2'b01, 8'h01, 1'b0, 1'b0); tick();
      drive(1'b1, 2'b11, 8'h77, 1'b0, 1'b0); tick();
      chk("t4_not_done_yet", 32'(ov_o[0]), 32'h0);
      drive(1'b1, 2'b01, 8'h01, logic'(rep), 1'b0); tick();
      chk($sformatf("t4_s_%0d", rep), 32'(s_o[0]), 32'h03);
      chk($sformatf("t4_cnt_%0d", rep), 32'(cnt_o[0]), 32'h4);
      chk($sformatf("t4_ov_%0d", rep), 32'(ov_o[0]), 32'h1);
      drive(1'b1, 2'b01, 8'h01, 1'b1, 1'b0); tick();
      chk($sformatf("t4_hold_cnt_%0d", rep), 32'(cnt_o[0]), 32'h4);
      chk($sformatf("t4_hold_ov_%0d", rep), 32'(ov_o[0]), 32'h1);
      drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1); tick();
    end

    // 5: retained accumulator across a stalled output handshake
    drive(1'b1, 2'b00, 8'h42, 1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b01, 8'h11, 1'b0, 1'b0); tick();
      chk("t5_stall_s", 32'(s_o[2]), 32'h42);
      chk("t5_stall_ov", 32'(ov_o[2]), 32'h1);
    end
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1); tick();
    chk("t5_hs_keep_s", 32'(s_o[2]), 32'h42);
    chk("t5_hs_clr_s", 32'(s_o[0]), 32'h00);
    drive(1'b1, 2'b01, 8'h01, 1'b1, 1'b0); tick();
    chk("t5_next_s", 32'(s_o[2]), 32'h43);
    chk("t5_next_clr_s", 32'(s_o[0]), 32'h01);
    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1); tick();

    // 6: random traffic against the reference model on every cycle
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive(1'b1, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      else
        drive(1'b0, 2'bxx, 8'hxx, 1'bx, 1'($urandom_range(0, 1)));
      tick();
      for (int k = 0; k < ND; k++) begin
        chk($sformatf("r_s_d%0d", k), 32'(s_o[k]), 32'(m_s[k]));
        chk($sformatf("r_cout_d%0d", k), 32'(c_o[k]), 32'(m_c[k]));
        chk($sformatf("r_ovf_d%0d", k), 32'(ovf_o[k]), 32'(m_o[k]));
        chk($sformatf("r_cnt_d%0d", k), 32'(cnt_o[k]), 32'(m_cnt));
        chk($sformatf("r_ov_d%0d", k), 32'(ov_o[k]), 32'(m_done));
      end
    end

    drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
    repeat (3) tick();
    chk("sb_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
